rdoq_tu_shift_scheduler: RTL

- Per-transform-unit (TU) scheduler in front of the RDOQ coefficient datapath.
- Accepts one TU descriptor through a valid/ready handshake.
- Computes and registers the TU's transform shift and quantizer bit count.
- Then issues one coefficient index per handshake to the downstream quantizer, flagging the last index and signalling TU completion, before accepting the next descriptor.

---
 rtl/rdoq_tu_shift_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rdoq_tu_shift_scheduler.sv
// Per-TU scheduler ahead of the RDOQ datapath: derives transform shift and
// q_bits for one descriptor, then issues every raster coefficient index once.
module rdoq_tu_shift_scheduler #(
   parameter int QUANT_SHIFT   = 14,
   parameter int MIN_LOG2_SIZE = 2,
   parameter int MAX_LOG2_SIZE = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              desc_valid,
   output logic              desc_ready,
   input  logic [3:0]        channel_bit_depth,
   input  logic [2:0]        log2_tr_size,
   input  logic [4:0]        max_log2_tr_dynamic_range,
   input  logic              use_transform_skip,
   input  logic              extended_precision_processing,
   input  logic [3:0]        qp_per,
   output logic signed [5:0] tu_transform_shift,
   output logic signed [7:0] tu_q_bits,
   output logic              coef_valid,
   input  logic              coef_ready,
   output logic [9:0]        coef_idx,
   output logic              coef_last,
   output logic              tu_done,
   output logic              tu_err
);

   typedef enum logic [2:0] {IDLE, CALC, ISSUE, DONE, ERR} state_t;

   state_t             state_q, state_d;
   logic [3:0]         depth_q, depth_d;
   logic [2:0]         log2_q, log2_d;
   logic [4:0]         range_q, range_d;
   logic               ts_q, ts_d;
   logic               ext_q, ext_d;
   logic [3:0]         qp_q, qp_d;
   logic signed [5:0]  shift_q, shift_d;
   logic signed [7:0]  q_bits_q, q_bits_d;
   logic [9:0]         idx_q, idx_d;

   logic [10:0]        span;
   logic [9:0]         last_idx;
   logic signed [6:0]  base;
   logic signed [5:0]  shift_calc;
   logic signed [7:0]  q_bits_calc;
   logic               size_ok;

   assign size_ok = (log2_tr_size >= 3'(MIN_LOG2_SIZE)) &&
                    (log2_tr_size <= 3'(MAX_LOG2_SIZE));

   // Terminal raster index is 4^log2 - 1; span never exceeds 1024.
   assign span     = 11'd1 << {log2_q, 1'b0};
   assign last_idx = 10'(span - 11'd1);

   assign base = {2'b00, range_q} - {3'b000, depth_q} - {4'b0000, log2_q};

   // Transform-skip with extended precision clamps a negative shift to zero.
   assign shift_calc  = (ts_q && ext_q && base[6]) ? 6'sd0 : base[5:0];
   assign q_bits_calc = 8'(QUANT_SHIFT) + {4'b0000, qp_q} +
                        {{2{shift_calc[5]}}, shift_calc};

   always_comb begin
      state_d  = state_q;
      depth_d  = depth_q;
      log2_d   = log2_q;
      range_d  = range_q;
      ts_d     = ts_q;
      ext_d    = ext_q;
      qp_d     = qp_q;
      shift_d  = shift_q;
      q_bits_d = q_bits_q;
      idx_d    = idx_q;
      unique case (state_q)
         IDLE: begin
            if (desc_valid) begin
               depth_d = channel_bit_depth;
               log2_d  = log2_tr_size;
               range_d = max_log2_tr_dynamic_range;
               ts_d    = use_transform_skip;
               ext_d   = extended_precision_processing;
               qp_d    = qp_per;
               state_d = size_ok ? CALC : ERR;
            end
         end
         CALC: begin
            shift_d  = shift_calc;
            q_bits_d = q_bits_calc;
            idx_d    = 10'd0;
            state_d  = ISSUE;
         end
         ISSUE: begin
            if (coef_ready) begin
               if (idx_q == last_idx) state_d = DONE;
               else                   idx_d   = idx_q + 10'd1;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         depth_q  <= '0;
         log2_q   <= '0;
         range_q  <= '0;
         ts_q     <= 1'b0;
         ext_q    <= 1'b0;
         qp_q     <= '0;
         shift_q  <= '0;
         q_bits_q <= '0;
         idx_q    <= '0;
      end else begin
         state_q  <= state_d;
         depth_q  <= depth_d;
         log2_q   <= log2_d;
         range_q  <= range_d;
         ts_q     <= ts_d;
         ext_q    <= ext_d;
         qp_q     <= qp_d;
         shift_q  <= shift_d;
         q_bits_q <= q_bits_d;
         idx_q    <= idx_d;
      end
   end

   assign desc_ready         = (state_q == IDLE);
   assign coef_valid         = (state_q == ISSUE);
   assign coef_last          = coef_valid && (idx_q == last_idx);
   assign tu_done            = (state_q == DONE);
   assign tu_err             = (state_q == ERR);
   assign coef_idx           = idx_q;
   assign tu_transform_shift = shift_q;
   assign tu_q_bits          = q_bits_q;

endmodule
